irq_ctrl: RTL and testbench

- Fixed-priority interrupt controller between the memory-mapped peripherals (timer `interupt_o` and others) and the core.
- Latches per-source requests, masks them with a software-written enable register, and presents one winning source ID to the core.
- Sequences the claim/complete handshake so each source is serviced exactly once per request.
- Register access comes through a simple cfg port driven by the AXI slave wrapper; the block itself holds no AXI logic.

---
 rtl/irq_ctrl_pkg.sv | 16 +
 rtl/irq_gateway.sv | 45 ++++
 rtl/irq_ctrl.sv | 136 +++++++++++++
 tb/tb_irq_ctrl.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/irq_ctrl_pkg.sv
// Shared register offsets, FSM encoding and widths for the interrupt controller.
package irq_ctrl_pkg;

  localparam int unsigned ADDR_W = 4;

  localparam logic [ADDR_W-1:0] REG_ENABLE    = 4'h0;
  localparam logic [ADDR_W-1:0] REG_PENDING   = 4'h4;
  localparam logic [ADDR_W-1:0] REG_INSERVICE = 4'h8;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    NOTIFY  = 2'd1,
    SERVICE = 2'd2
  } irq_state_e;

endpackage

// File: rtl/irq_gateway.sv
// Per-source gateway: latches one pending request until it is claimed.
// IRQ_EDGE_EN selects synchronized edge detection instead of level capture.
module irq_gateway (
  input  logic clk,
  input  logic rst_n,
  input  logic src,
  input  logic in_service,
  input  logic claim,
  output logic pending
);

  logic set_c;

`ifdef IRQ_EDGE_EN
  logic [2:0] sync_q;
  logic       unused_c;

  // Two synchronizer flops plus one history flop for rising-edge detection.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
    end else begin
      sync_q <= {sync_q[1:0], src};
    end
  end

  assign set_c    = sync_q[1] & ~sync_q[2];
  assign unused_c = in_service;
`else
  // A level source is ignored while it is being serviced, so it re-pends only after completion.
  assign set_c = src & ~in_service;
`endif

  // Claim beats a coincident set so a request is never serviced twice.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending <= 1'b0;
    end else if (claim) begin
      pending <= 1'b0;
    end else if (set_c) begin
      pending <= 1'b1;
    end
  end

endmodule

// File: rtl/irq_ctrl.sv
// Fixed-priority interrupt controller with claim/complete handshake (source 0 highest).
// Define IRQ_EDGE_EN for edge-triggered, synchronized sources.
module irq_ctrl
  import irq_ctrl_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 4,
  parameter int unsigned ID_W     = 2,
  parameter int unsigned WIDTH_DA = 32
) (
  input  logic                S_AXI_ACLK,
  input  logic                S_AXI_ARESETN,
  input  logic [NUM_SRC-1:0]  irq_src_i,
  input  logic                cfg_wr_i,
  input  logic                cfg_rd_i,
  input  logic [ADDR_W-1:0]   cfg_addr_i,
  input  logic [WIDTH_DA-1:0] cfg_wdata_i,
  output logic [WIDTH_DA-1:0] cfg_rdata_o,
  output logic                cfg_rvalid_o,
  output logic                irq_o,
  output logic [ID_W-1:0]     irq_id_o,
  input  logic                claim_i,
  input  logic                complete_i,
  input  logic [ID_W-1:0]     complete_id_i
);

  irq_state_e         state_q;
  logic [NUM_SRC-1:0] enable_q;
  logic [NUM_SRC-1:0] in_service_q;
  logic [NUM_SRC-1:0] pending;
  logic [NUM_SRC-1:0] claim_vec_c;
  logic [NUM_SRC-1:0] req_c;
  logic               any_c;
  logic [ID_W-1:0]    win_c;
  logic [WIDTH_DA-1:0] rdata_c;
  logic               unused_c;

  assign unused_c = ^cfg_wdata_i[WIDTH_DA-1:NUM_SRC];

  for (genvar g = 0; g < NUM_SRC; g++) begin : g_gw
    irq_gateway u_gw (
      .clk        (S_AXI_ACLK),
      .rst_n      (S_AXI_ARESETN),
      .src        (irq_src_i[g]),
      .in_service (in_service_q[g]),
      .claim      (claim_vec_c[g]),
      .pending    (pending[g])
    );
  end

  assign req_c       = pending & enable_q;
  assign claim_vec_c = (state_q == NOTIFY && claim_i) ? (NUM_SRC'(1) << irq_id_o) : '0;

  // Lowest enabled pending index wins; scan from the top so index 0 is applied last.
  always_comb begin
    any_c = 1'b0;
    win_c = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req_c[i]) begin
        any_c = 1'b1;
        win_c = ID_W'(i);
      end
    end
  end

  always_comb begin
    rdata_c = '0;
    case (cfg_addr_i)
      REG_ENABLE:    rdata_c = WIDTH_DA'(enable_q);
      REG_PENDING:   rdata_c = WIDTH_DA'(pending);
      REG_INSERVICE: rdata_c = WIDTH_DA'(in_service_q);
      default:       rdata_c = '0;
    endcase
  end

  // Register port: read data reflects pre-write state when write and read coincide.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      enable_q     <= '0;
      cfg_rdata_o  <= '0;
      cfg_rvalid_o <= 1'b0;
    end else begin
      cfg_rvalid_o <= cfg_rd_i;
      if (cfg_rd_i) begin
        cfg_rdata_o <= rdata_c;
      end
      if (cfg_wr_i && cfg_addr_i == REG_ENABLE) begin
        enable_q <= cfg_wdata_i[NUM_SRC-1:0];
      end
    end
  end

  // Handshake FSM; irq_id_o doubles as the in-service ID while in SERVICE.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state_q      <= IDLE;
      irq_o        <= 1'b0;
      irq_id_o     <= '0;
      in_service_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          irq_o <= 1'b0;
          if (any_c) begin
            state_q  <= NOTIFY;
            irq_o    <= 1'b1;
            irq_id_o <= win_c;
          end
        end
        NOTIFY: begin
          if (claim_i) begin
            state_q      <= SERVICE;
            irq_o        <= 1'b0;
            in_service_q <= claim_vec_c;
          end else if (!any_c) begin
            state_q <= IDLE;
            irq_o   <= 1'b0;
          end else begin
            irq_id_o <= win_c;
          end
        end
        SERVICE: begin
          irq_o <= 1'b0;
          if (complete_i && complete_id_i == irq_id_o) begin
            state_q      <= IDLE;
            in_service_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          irq_o   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_irq_ctrl.sv
// Directed self-checking bench for irq_ctrl (default level-triggered build).
module tb_irq_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [3:0]  src;
  logic        cfg_wr, cfg_rd;
  logic [3:0]  cfg_addr;
  logic [31:0] cfg_wdata, cfg_rdata;
  logic        cfg_rvalid;
  logic        irq;
  logic [1:0]  irq_id;
  logic        claim, complete;
  logic [1:0]  complete_id;

  int n_cmp = 0;
  int n_err = 0;

  logic [31:0] rd;
  logic        rv;

  irq_ctrl dut (
    .S_AXI_ACLK    (clk),
    .S_AXI_ARESETN (rst_n),
    .irq_src_i     (src),
    .cfg_wr_i      (cfg_wr),
    .cfg_rd_i      (cfg_rd),
    .cfg_addr_i    (cfg_addr),
    .cfg_wdata_i   (cfg_wdata),
    .cfg_rdata_o   (cfg_rdata),
    .cfg_rvalid_o  (cfg_rvalid),
    .irq_o         (irq),
    .irq_id_o      (irq_id),
    .claim_i       (claim),
    .complete_i    (complete),
    .complete_id_i (complete_id)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic cfg_write(input logic [3:0] a, input logic [31:0] d);
    cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
    tick();
    cfg_wr = 1'b0;
  endtask

  task automatic cfg_read(input logic [3:0] a, output logic [31:0] d, output logic v);
    cfg_rd = 1'b1; cfg_addr = a;
    tick();
    d = cfg_rdata; v = cfg_rvalid;
    cfg_rd = 1'b0;
  endtask

  task automatic do_claim();
    claim = 1'b1; tick(); claim = 1'b0;
  endtask

  task automatic do_complete(input logic [1:0] id);
    complete = 1'b1; complete_id = id; tick(); complete = 1'b0;
  endtask

  task automatic test_reset();
    #1;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b want 0", irq); end
    n_cmp++; if (irq_id !== 2'd0) begin n_err++; $display("FAIL reset_id: got %0d want 0", irq_id); end
    n_cmp++; if (cfg_rvalid !== 1'b0) begin n_err++; $display("FAIL reset_rvalid: got %b want 0", cfg_rvalid); end
    n_cmp++; if (cfg_rdata !== 32'h0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", cfg_rdata); end
    tick(); tick();
    rst_n = 1'b1;
    tick();
    cfg_read(4'h0, rd, rv);
    n_cmp++; if (rd !== 32'h0 || rv !== 1'b1) begin n_err++; $display("FAIL reset_enable: got %h/%b want 0/1", rd, rv); end
    tick();
    n_cmp++; if (cfg_rvalid !== 1'b0) begin n_err++; $display("FAIL rvalid_pulse: got %b want 0", cfg_rvalid); end
    cfg_read(4'h4, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_pending: got %h want 0", rd); end
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL reset_inservice: got %h want 0", rd); end
  endtask

  task automatic test_basic();
    cfg_write(4'h0, 32'h1);
    cfg_read(4'h0, rd, rv);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL enable_rb: got %h want 1", rd); end
    src = 4'b0001; tick(); src = 4'b0000;
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_n1_irq: got %b want 0", irq); end
    cfg_read(4'h4, rd, rv);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL basic_pending: got %h want 1", rd); end
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd0) begin n_err++; $display("FAIL basic_n2_irq: got %b/%0d want 1/0", irq, irq_id); end
    do_claim();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL basic_claim_irq: got %b want 0", irq); end
    cfg_read(4'h4, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_claim_pending: got %h want 0", rd); end
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h1) begin n_err++; $display("FAIL basic_inservice: got %h want 1", rd); end
    cfg_read(4'hC, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL unmapped_read: got %h want 0", rd); end
    do_complete(2'd0);
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL basic_complete: got %h want 0", rd); end
  endtask

  task automatic test_priority();
    cfg_write(4'h0, 32'hF);
    src = 4'b0110; tick(); src = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1) begin n_err++; $display("FAIL prio_first: got %b/%0d want 1/1", irq, irq_id); end
    do_claim();
    do_complete(2'd1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL prio_gap: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL prio_second: got %b/%0d want 1/2", irq, irq_id); end
    do_claim();
    do_complete(2'd2);
  endtask

  task automatic test_mask_preempt();
    cfg_write(4'h0, 32'h4);
    src = 4'b0100; tick(); src = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL mask_start: got %b/%0d want 1/2", irq, irq_id); end
    src = 4'b0001; tick(); src = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL mask_hold: got %b/%0d want 1/2", irq, irq_id); end
    // Same-cycle write and read of ENABLE returns the old value.
    cfg_wr = 1'b1; cfg_rd = 1'b1; cfg_addr = 4'h0; cfg_wdata = 32'hFFFF_FFF5;
    tick();
    cfg_wr = 1'b0; cfg_rd = 1'b0;
    n_cmp++; if (cfg_rdata !== 32'h4) begin n_err++; $display("FAIL wr_rd_same: got %h want 4", cfg_rdata); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd0) begin n_err++; $display("FAIL preempt: got %b/%0d want 1/0", irq, irq_id); end
    cfg_read(4'h0, rd, rv);
    n_cmp++; if (rd !== 32'h5) begin n_err++; $display("FAIL enable_upper: got %h want 5", rd); end
    do_claim();
    do_complete(2'd0);
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd2) begin n_err++; $display("FAIL mask_resume: got %b/%0d want 1/2", irq, irq_id); end
    do_claim();
    do_complete(2'd2);
  endtask

  task automatic test_complete_mismatch();
    cfg_write(4'h0, 32'h8);
    cfg_write(4'h4, 32'hF);
    src = 4'b1000; tick(); src = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd3) begin n_err++; $display("FAIL mm_notify: got %b/%0d want 1/3", irq, irq_id); end
    do_claim();
    do_complete(2'd1);
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL mm_ignored: got %h want 8", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL mm_irq: got %b want 0", irq); end
    do_complete(2'd3);
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL mm_complete: got %h want 0", rd); end
  endtask

  task automatic test_hold_level();
    cfg_write(4'h0, 32'h2);
    src = 4'b0010;
    tick(); tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1) begin n_err++; $display("FAIL hold_notify: got %b/%0d want 1/1", irq, irq_id); end
    do_claim();
    cfg_read(4'h4, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL hold_no_repend: got %h want 0", rd); end
    do_complete(2'd1);
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL hold_c1: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL hold_c2: got %b want 0", irq); end
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd1) begin n_err++; $display("FAIL hold_reassert: got %b/%0d want 1/1", irq, irq_id); end
    src = 4'b0000;
    do_claim();
    do_complete(2'd1);
  endtask

  task automatic test_async_reset();
    cfg_write(4'h0, 32'h8);
    src = 4'b1000; tick(); src = 4'b0000;
    tick();
    n_cmp++; if (irq !== 1'b1 || irq_id !== 2'd3) begin n_err++; $display("FAIL ar_notify: got %b/%0d want 1/3", irq, irq_id); end
    cfg_read(4'h0, rd, rv);
    n_cmp++; if (rd !== 32'h8) begin n_err++; $display("FAIL ar_enable: got %h want 8", rd); end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++; if (irq !== 1'b0 || irq_id !== 2'd0) begin n_err++; $display("FAIL ar_irq: got %b/%0d want 0/0", irq, irq_id); end
    n_cmp++; if (cfg_rdata !== 32'h0 || cfg_rvalid !== 1'b0) begin n_err++; $display("FAIL ar_cfg: got %h/%b want 0/0", cfg_rdata, cfg_rvalid); end
    #2 rst_n = 1'b1;
    cfg_read(4'h0, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ar_enable_clr: got %h want 0", rd); end
    cfg_read(4'h4, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ar_pending_clr: got %h want 0", rd); end
    cfg_read(4'h8, rd, rv);
    n_cmp++; if (rd !== 32'h0) begin n_err++; $display("FAIL ar_inservice_clr: got %h want 0", rd); end
    n_cmp++; if (irq !== 1'b0) begin n_err++; $display("FAIL ar_irq_after: got %b want 0", irq); end
  endtask

  initial begin
    rst_n = 1'b0; src = '0;
    cfg_wr = 1'b0; cfg_rd = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    claim = 1'b0; complete = 1'b0; complete_id = '0;
    test_reset();
    test_basic();
    test_priority();
    test_mask_preempt();
    test_complete_mismatch();
    test_hold_level();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
